stop_watch: RTL and testbench
=============================

STOP_WATCH -- requirements
Module: stop_watch

Interface
REQ-001 Parameter CLK_DIV, default 10, number of clk cycles per time_o increment while RUNNING; legal range 1..1023.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 nRst_i  input  1  reset, asynchronous and active-high; asserted (1) forces reset state immediately, independent of clk; the name is retained from the codebase, polarity is active-high.
REQ-004 button_i  input  1  asynchronous push-button, high = pressed.
REQ-005 mode_o  output  3  current mode: IDLE=3'b000, CLEAR=3'b001, RUNNING=3'b010; other codes never driven.
REQ-006 time_o  output  5  elapsed-time count, unsigned.

Function
REQ-007 button_i SHALL pass through a 2-flop synchronizer, then a rising-edge detector: press = sync_out & ~sync_out_prev.
REQ-008 Each press SHALL advance the mode IDLE->CLEAR->RUNNING->IDLE, exactly one step per press.
REQ-009 A button held high for any number of cycles SHALL produce exactly one advance; release produces none.
REQ-010 Latency: if button_i is first sampled high at rising edge k, mode_o SHALL show the new mode after rising edge k+2 and be stable 5 cycles after the press.
REQ-011 mode_o and time_o SHALL be registered outputs, glitch-free, driven directly from state flops.
REQ-012 CLEAR: time_o SHALL be 0 and the prescaler SHALL be 0 on every cycle in CLEAR.
REQ-013 RUNNING: the prescaler SHALL count 0..CLK_DIV-1; on the cycle it equals CLK_DIV-1, it SHALL return to 0 and time_o SHALL increment by 1.
REQ-014 First increment after entering RUNNING from CLEAR SHALL occur CLK_DIV cycles after entry; time_o = N after N*CLK_DIV cycles in RUNNING.
REQ-015 IDLE: time_o and prescaler SHALL hold their values (pause); re-entry to RUNNING is only via CLEAR, so time always restarts from 0.
REQ-016 Wrap: time_o at 31 with an increment due SHALL become 0 (modulo 32) unless REQ-022 applies.
REQ-017 A press on the same cycle as a due increment: the increment SHALL complete using the current mode, and the mode change takes effect that same edge.

Reset
REQ-018 While nRst_i=1: mode_o=IDLE, time_o=0, prescaler=0, synchronizer and edge-detect flops=0, regardless of clk or button_i.
REQ-019 Reset values SHALL hold for the whole duration of reset, including across clock edges and with button_i held high.
REQ-020 Reset release away from a clock edge SHALL leave mode_o=IDLE, time_o=0 until a subsequent press is detected.
REQ-021 Reset asserted mid-RUNNING SHALL abort counting immediately; no partial increment.

Configuration
REQ-022 Macro STOP_WATCH_SATURATE_EN: defined -> time_o saturates at 31 in RUNNING, and the prescaler keeps cycling with no further change; undefined -> modulo-32 wrap per REQ-016.

Verification
REQ-023 Assert nRst_i=1 with button_i=1, check at +2 ns, across a clock edge, and after release -> mode_o=000, time_o=0 throughout.
REQ-024 From reset, three single-cycle presses, each followed by 5 cycles -> mode_o 001 (CLEAR), then 010 (RUNNING), then 000 (IDLE).
REQ-025 CLK_DIV=10: CLEAR->RUNNING, wait 35 cycles, press to IDLE -> time_o=3, held for 50 cycles in IDLE; next press -> CLEAR, time_o=0.
REQ-026 Hold button_i high 20 cycles from IDLE -> mode_o=001 only, no further advance.
REQ-027 RUNNING for 330 cycles (CLK_DIV=10) -> without macro time_o=1 (wrap after 31); with STOP_WATCH_SATURATE_EN time_o=31.
REQ-028 Assert nRst_i=1 mid-RUNNING at time_o=7 -> mode_o=000, time_o=0 before the next clock edge.

Source files
------------

// File: rtl/stop_watch.sv
// Stopwatch: one push-button cycles IDLE -> CLEAR -> RUNNING -> IDLE; time_o counts every CLK_DIV clocks while RUNNING.
// Build option: define STOP_WATCH_SATURATE_EN to hold time_o at 31 instead of wrapping modulo 32.
module stop_watch #(
  parameter int CLK_DIV = 10
) (
  input  logic       clk,
  input  logic       nRst_i,
  input  logic       button_i,
  output logic [2:0] mode_o,
  output logic [4:0] time_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    CLEAR   = 3'b001,
    RUNNING = 3'b010
  } mode_t;

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

  logic       sync_meta;
  logic       sync_out;
  logic       sync_prev;
  logic       press;
  mode_t      mode;
  logic [9:0] presc;
  logic [4:0] count;

  // Button synchronizer plus one extra flop for rising-edge detection
  always_ff @(posedge clk or posedge nRst_i) begin
    if (nRst_i) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_meta <= button_i;
      sync_out  <= sync_meta;
      sync_prev <= sync_out;
    end
  end

  assign press = sync_out & ~sync_prev;

  function automatic logic [4:0] bump(input logic [4:0] t);
`ifdef STOP_WATCH_SATURATE_EN
    return (t == 5'd31) ? t : t + 5'd1;
`else
    return t + 5'd1;
`endif
  endfunction

  // Mode and counters; a due increment still uses the current mode when a press lands on the same edge
  always_ff @(posedge clk or posedge nRst_i) begin
    if (nRst_i) begin
      mode  <= IDLE;
      presc <= '0;
      count <= '0;
    end else begin
      case (mode)
        IDLE: begin
          if (press) begin
            mode  <= CLEAR;
            presc <= '0;
            count <= '0;
          end
        end
        CLEAR: begin
          presc <= '0;
          count <= '0;
          if (press) mode <= RUNNING;
        end
        RUNNING: begin
          if (presc == DIV_LAST) begin
            presc <= '0;
            count <= bump(count);
          end else begin
            presc <= presc + 10'd1;
          end
          if (press) mode <= IDLE;
        end
        default: begin
          mode  <= IDLE;
          presc <= '0;
          count <= '0;
        end
      endcase
    end
  end

  assign mode_o = mode;
  assign time_o = count;

endmodule

// File: tb/tb_stop_watch.sv
// Bench for stop_watch: directed scenarios followed by randomized button/reset traffic against a behavioural model.
module tb_stop_watch;

  localparam int CLK_DIV = 10;

  logic       clk = 1'b0;
  logic       nRst_i;
  logic       button_i;
  logic [2:0] mode_o;
  logic [4:0] time_o;

  int n_vec = 0;
  int n_bad = 0;

  // Model: mode index (0 idle, 1 clear, 2 running), clocks spent running since last clear, button sample history
  int mode_m;
  int run_cycles;
  bit samples[$];

  stop_watch #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .nRst_i   (nRst_i),
    .button_i (button_i),
    .mode_o   (mode_o),
    .time_o   (time_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, actual, expected);
    end
  endtask

  function automatic int model_time();
    int q;
    q = run_cycles / CLK_DIV;
`ifdef STOP_WATCH_SATURATE_EN
    return (q > 31) ? 31 : q;
`else
    return q % 32;
`endif
  endfunction

  task automatic model_reset();
    mode_m     = 0;
    run_cycles = 0;
    samples    = {};
    repeat (3) samples.push_back(1'b0);
  endtask

  // A press acts two edges after the button is first sampled high, given it was low the sample before
  task automatic model_edge();
    bit press;
    int n;
    samples.push_back(button_i);
    n = samples.size();
    press = samples[n-3] && !samples[n-4];
    if (n > 8) samples.pop_front();
    if (mode_m == 2) run_cycles++;
    if (press) begin
      mode_m = (mode_m + 1) % 3;
      if (mode_m == 1) run_cycles = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!nRst_i) model_edge();
    #1;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, "_mode"}, int'(mode_o), mode_m);
    check({tag, "_time"}, int'(time_o), model_time());
  endtask

  task automatic press();
    button_i = 1'b1;
    tick();
    button_i = 1'b0;
  endtask

  task automatic press_settle();
    press();
    repeat (5) tick();
  endtask

  initial begin
    int guard;
    int hold;
    int expect_wrap;

    // Reset held with the button pressed, checked off-edge and across edges
    nRst_i   = 1'b1;
    button_i = 1'b1;
    model_reset();
    #2;
    check("rst_2ns_mode", int'(mode_o), 0);
    check("rst_2ns_time", int'(time_o), 0);
    tick();
    check("rst_edge_mode", int'(mode_o), 0);
    check("rst_edge_time", int'(time_o), 0);
    tick();
    #2;
    button_i = 1'b0;
    nRst_i   = 1'b0;
    check("rst_rel_mode", int'(mode_o), 0);
    check("rst_rel_time", int'(time_o), 0);
    repeat (4) tick();
    check("post_rel_mode", int'(mode_o), 0);
    cmp_model("post_rel");

    // Three single presses walk the mode sequence
    press_settle();
    check("seq_clear", int'(mode_o), 1);
    press_settle();
    check("seq_running", int'(mode_o), 2);
    press_settle();
    check("seq_idle", int'(mode_o), 0);
    cmp_model("seq");

    // Run about 36 clocks, pause and hold, then clear
    press_settle();
    press();
    repeat (35) tick();
    press();
    repeat (25) tick();
    check("pause_mid_time", int'(time_o), 3);
    repeat (25) tick();
    check("pause_mode", int'(mode_o), 0);
    check("pause_time", int'(time_o), 3);
    cmp_model("pause");
    press_settle();
    check("reclear_mode", int'(mode_o), 1);
    check("reclear_time", int'(time_o), 0);

    // Long hold from IDLE gives exactly one advance
    press_settle();
    press_settle();
    check("hold_pre_mode", int'(mode_o), 0);
    button_i = 1'b1;
    repeat (20) tick();
    check("hold_mode", int'(mode_o), 1);
    button_i = 1'b0;
    repeat (5) tick();
    check("hold_rel_mode", int'(mode_o), 1);
    cmp_model("hold");

    // 330 running clocks: wrap or saturate
    press();
    tick();
    tick();
    check("long_entry_mode", int'(mode_o), 2);
    check("long_entry_time", int'(time_o), 0);
    repeat (330) tick();
`ifdef STOP_WATCH_SATURATE_EN
    expect_wrap = 31;
`else
    expect_wrap = 1;
`endif
    check("long_time", int'(time_o), expect_wrap);
    cmp_model("long");

    // Reset in the middle of running at time 7
    press_settle();
    press_settle();
    press();
    guard = 0;
    while (model_time() != 7 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) check("t7_reach", model_time(), 7);
    repeat (3) tick();
    check("t7_time", int'(time_o), 7);
    #2;
    nRst_i = 1'b1;
    model_reset();
    #1;
    check("midrun_rst_mode", int'(mode_o), 0);
    check("midrun_rst_time", int'(time_o), 0);
    repeat (2) tick();
    check("midrun_hold_time", int'(time_o), 0);
    #2;
    nRst_i = 1'b0;
    repeat (3) tick();
    cmp_model("midrun_rel");

    // Random button traffic with occasional resets
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2;
        nRst_i = 1'b1;
        model_reset();
        #1;
        check("rnd_rst_mode", int'(mode_o), 0);
        check("rnd_rst_time", int'(time_o), 0);
        repeat ($urandom_range(1, 3)) tick();
        #2;
        button_i = 1'($urandom_range(0, 1));
        nRst_i   = 1'b0;
      end else begin
        if (hold == 0) begin
          button_i = ~button_i;
          hold = button_i ? $urandom_range(1, 6) : $urandom_range(1, 80);
        end
        hold--;
        tick();
        cmp_model("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
